uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, parametrised UART transmitter for the UART subsystem, successor to the plain single-byte TX path. Frames are queued in an internal FIFO and sent back-to-back with no idle gap. An internal bit-period divider runs from the system clock, so no separate TX clock is needed. Parity mode, parity type and one or two stop bits are latched per frame, and FIFO occupancy and overflow are reported to the register file.

## Interface
- DATA_WIDTH, 8, payload bits per frame (5–9)
- FIFO_DEPTH, 8, FIFO entries (power of two, ≥2)
- PRESCALE_MAX, 32, largest supported bit period in CLK cycles
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  asynchronous, active-high reset
- WR_Data  input  DATA_WIDTH  word to enqueue
- WR_En  input  1  enqueue request, sampled each cycle
- Prescale  input  $clog2(PRESCALE_MAX)+1  bit period in cycles; 0 treated as 1
- PAR_EN  input  1  parity bit enable
- PAR_TYP  input  1  0 = even, 1 = odd
- STOP2  input  1  1 = two stop bits
- OVF_CLR  input  1  clears OVERFLOW
- TX_OUT  output  1  serial line, idles high
- Busy  output  1  frame in progress (state ≠ IDLE)
- FULL  output  1  FIFO full (registered)
- COUNT  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- OVERFLOW  output  1  sticky: a write was dropped

## Operation
- Write: WR_En & !FULL stores WR_Data. WR_En & FULL drops the word and sets OVERFLOW.
- FULL is the registered status. A write while FULL is dropped even if a pop happens in the same cycle.
- OVERFLOW clears on OVF_CLR. If OVF_CLR and a dropped write occur in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when COUNT ≠ 0, pop the head word. In the same cycle latch the word, PAR_EN, PAR_TYP, STOP2 and Prescale, then go to START.
  - START: TX_OUT = 0 for one bit period, then go to DATA.
  - DATA: DATA_WIDTH bits, LSB first, one bit period each, then go to PARITY if PAR_EN, else STOP.
  - PARITY: TX_OUT = XOR(data) ^ PAR_TYP for one bit period, then go to STOP.
  - STOP: TX_OUT = 1 for one bit period, or two if STOP2. On the last cycle of the last stop bit, pop and go to START if COUNT ≠ 0, otherwise go to IDLE.
- Config input changes mid-frame have no effect until the next pop.
- Bit-period counter: loads Prescale−1 (minimum 0) at each bit start, decrements, and advances the bit at 0.
- Frame length = (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × max(Prescale, 1) cycles.
- Pop and write in the same cycle when not FULL: both take effect and COUNT is unchanged.

## Timing
- Reset values: TX_OUT = 1, Busy = 0, FULL = 0, COUNT = 0, OVERFLOW = 0. FSM goes to IDLE and the FIFO is emptied.
- Reset mid-frame: TX_OUT returns high immediately (asynchronous) and the partial frame is abandoned.
- Write at edge n into an empty FIFO: COUNT = 1 after n, pop at n+1, TX_OUT = 0 and Busy = 1 after n+1. Start-of-frame latency is 2 cycles.
- Back-to-back frames have zero idle cycles between stop and start.
- TX_OUT is registered and glitch-free.

## Structure
- Package uart_pkg: FSM state encoding, parity-type constants (PAR_EVEN = 0, PAR_ODD = 1), and a width function for COUNT.
- Sub-module uart_sync_fifo, a single-clock FIFO with DATA_WIDTH/FIFO_DEPTH parameters:
  - ports: wr_en, wr_data, rd_en, rd_data, full, count
  - rd_data is show-ahead, so the head word is valid when count ≠ 0
  - wrap-around uses pointers with one extra bit
- Top level contains the FSM, bit-period counter, bit index, shift register and parity logic.

## Test plan
- Prescale = 4, 8N1, single write 0xA5 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; Busy high for 40 cycles; start-of-frame latency is 2 cycles.
- PAR_EN = 1, PAR_TYP = 0 then 1, data 0x07 -> parity bit 1 (even), then 0 (odd); STOP2 = 1 gives 2 stop periods; 8E2 frame = 12 bit periods.
- Write 3 words back-to-back at Prescale = 2 -> three contiguous frames with no high gap beyond the stop bits; COUNT sequence 1,2,3 then decrements at each pop.
- Fill FIFO_DEPTH = 8 while Prescale = 32, then write 0xFF -> FULL = 1, COUNT = 8, OVERFLOW = 1, 0xFF never transmitted; OVF_CLR clears OVERFLOW.
- Assert RST mid-DATA of a frame with 2 words queued -> TX_OUT = 1, COUNT = 0 and Busy = 0 immediately; no frame after release until a new write.
- Prescale = 0 and then 1 -> 1-cycle bit periods; toggle PAR_EN mid-frame -> current frame unchanged, next frame uses the new setting.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// parity-type constants and the occupancy-counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } txState_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // One extra bit so a completely full FIFO can be represented.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit so
// occupancy is their difference and full/empty are unambiguous.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = countWidth(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]         wrPtr_q, wrPtr_d;
  logic [CW-1:0]         rdPtr_q, rdPtr_d;
  logic                  full_q, full_d;
  logic                  wrAccept, rdAccept;

  assign count   = wrPtr_q - rdPtr_q;
  assign full    = full_q;
  assign rd_data = mem[rdPtr_q[AW-1:0]];

  // Writes are gated by the registered full flag, so a same-cycle pop
  // never rescues a write that arrives while full.
  always_comb begin
    wrAccept = wr_en && !full_q;
    rdAccept = rd_en && (count != '0);
    wrPtr_d  = wrPtr_q + CW'(wrAccept);
    rdPtr_d  = rdPtr_q + CW'(rdAccept);
    full_d   = (wrPtr_d - rdPtr_d) == CW'(FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrPtr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with a per-frame latched
// configuration, internal bit-period divider and registered serial output.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int PRESCALE_MAX = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         WR_Data,
  input  logic                          WR_En,
  input  logic [$clog2(PRESCALE_MAX):0] Prescale,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic                          OVF_CLR,
  output logic                          TX_OUT,
  output logic                          Busy,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          OVERFLOW
);

  localparam int PW = $clog2(PRESCALE_MAX) + 1;
  localparam int IW = $clog2(DATA_WIDTH);

  txState_e              state_q, state_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         period_q, period_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parEn_q, parEn_d;
  logic                  parBit_q, parBit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q, ovf_d;

  logic                  pop, loadNext, bitDone;
  logic [PW-1:0]         presetIn;
  logic [DATA_WIDTH-1:0] headData;
  logic                  fifoFull;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (WR_En),
    .wr_data (WR_Data),
    .rd_en   (pop),
    .rd_data (headData),
    .full    (fifoFull),
    .count   (fifoCount)
  );

  assign TX_OUT   = tx_q;
  assign Busy     = (state_q != ST_IDLE);
  assign FULL     = fifoFull;
  assign COUNT    = fifoCount;
  assign OVERFLOW = ovf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parEn_d  = parEn_q;
    parBit_d = parBit_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    loadNext = 1'b0;
    bitDone  = (cnt_q == '0);
    presetIn = (Prescale == '0) ? '0 : Prescale - PW'(1);

    if (state_q != ST_IDLE && !bitDone) begin
      cnt_d = cnt_q - PW'(1);
    end

    // tx_d always holds the level of the bit that starts on this edge.
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (fifoCount != '0) loadNext = 1'b1;
      end
      ST_START: begin
        if (bitDone) begin
          state_d = ST_DATA;
          cnt_d   = period_q;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bitDone) begin
          cnt_d = period_q;
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
            idx_d = '0;
            if (parEn_q) begin
              state_d = ST_PARITY;
              tx_d    = parBit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bitDone) begin
          state_d = ST_STOP;
          cnt_d   = period_q;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bitDone) begin
          if (stop2_q && idx_q == '0) begin
            idx_d = IW'(1);
            cnt_d = period_q;
          end else if (fifoCount != '0) begin
            loadNext = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Configuration is sampled only here, so mid-frame input changes wait for the next pop.
    if (loadNext) begin
      pop      = 1'b1;
      state_d  = ST_START;
      cnt_d    = presetIn;
      period_d = presetIn;
      shift_d  = headData;
      parEn_d  = PAR_EN;
      parBit_d = (^headData) ^ (PAR_TYP == PAR_ODD);
      stop2_d  = STOP2;
      tx_d     = 1'b0;
    end

    if (WR_En && fifoFull) ovf_d = 1'b1;
    else if (OVF_CLR)      ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parEn_q  <= 1'b0;
      parBit_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parEn_q  <= parEn_d;
      parBit_q <= parBit_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a table of single-frame vectors with
// hand-written bit strings, plus sequences for queueing, overflow and reset.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] WR_Data;
  logic       WR_En;
  logic [5:0] Prescale;
  logic       PAR_EN, PAR_TYP, STOP2, OVF_CLR;
  logic       TX_OUT, Busy, FULL, OVERFLOW;
  logic [3:0] COUNT;

  int checks = 0;
  int errors = 0;
  logic expQ[$];

  typedef struct {
    logic [7:0] data;
    logic [5:0] presc;
    logic       parEn;
    logic       parTyp;
    logic       stop2;
    int         period;
    string      bits;
  } vec_t;

  vec_t vecs[6];

  uart_tx_fifo #(
    .DATA_WIDTH   (8),
    .FIFO_DEPTH   (8),
    .PRESCALE_MAX (32)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_Data  (WR_Data),
    .WR_En    (WR_En),
    .Prescale (Prescale),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .STOP2    (STOP2),
    .OVF_CLR  (OVF_CLR),
    .TX_OUT   (TX_OUT),
    .Busy     (Busy),
    .FULL     (FULL),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic [7:0] data, input logic en, input logic [5:0] presc,
                               input logic parEn, input logic parTyp, input logic stop2,
                               input logic ovfClr);
    WR_Data  = data;
    WR_En    = en;
    Prescale = presc;
    PAR_EN   = parEn;
    PAR_TYP  = parTyp;
    STOP2    = stop2;
    OVF_CLR  = ovfClr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Appends an 8N1 frame to the expected serial stream, each bit held period cycles.
  task automatic pushFrame(input logic [7:0] w, input int period);
    logic b;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      b = 1'b0;
      else if (k == 9) b = 1'b1;
      else             b = w[k-1];
      for (int c = 0; c < period; c++) expQ.push_back(b);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 6'd4, 1'b0, 1'b0, 1'b0, 4, "0101001011"};
    vecs[1] = '{8'h07, 6'd2, 1'b1, 1'b0, 1'b0, 2, "01110000011"};
    vecs[2] = '{8'h07, 6'd2, 1'b1, 1'b1, 1'b1, 2, "011100000011"};
    vecs[3] = '{8'h3C, 6'd0, 1'b0, 1'b0, 1'b0, 1, "0001111001"};
    vecs[4] = '{8'h80, 6'd1, 1'b1, 1'b1, 1'b0, 1, "00000000101"};
    vecs[5] = '{8'h55, 6'd3, 1'b1, 1'b0, 1'b1, 3, "010101010011"};

    RST = 1'b1;
    applyStimulus(8'h00, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("rst_tx", TX_OUT, 1'b1);
    checkOutput("rst_busy", Busy, 1'b0);
    checkOutput("rst_full", FULL, 1'b0);
    checkOutput("rst_count", COUNT, 4'd0);
    checkOutput("rst_ovf", OVERFLOW, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Three words queued behind a running frame at Prescale 2.
    expQ.delete();
    pushFrame(8'h11, 2); pushFrame(8'h22, 2); pushFrame(8'h33, 2); pushFrame(8'h44, 2);
    applyStimulus(8'h11, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 81; n++) begin
      @(negedge CLK);
      if (n >= 2) checkOutput($sformatf("b2b_tx[%0d]", n - 2), TX_OUT, expQ[n-2]);
      if (n == 3)  checkOutput("b2b_count1", COUNT, 4'd1);
      if (n == 4)  checkOutput("b2b_count2", COUNT, 4'd2);
      if (n == 5)  checkOutput("b2b_count3", COUNT, 4'd3);
      if (n == 22) checkOutput("b2b_pop2", COUNT, 4'd2);
      if (n == 42) checkOutput("b2b_pop3", COUNT, 4'd1);
      if (n == 62) checkOutput("b2b_pop4", COUNT, 4'd0);
      case (n)
        1:       WR_En = 1'b0;
        2:       applyStimulus(8'h22, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        3:       applyStimulus(8'h33, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        4:       applyStimulus(8'h44, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        5:       WR_En = 1'b0;
        default: ;
      endcase
    end
    @(negedge CLK);
    checkOutput("b2b_idle_busy", Busy, 1'b0);
    checkOutput("b2b_idle_tx", TX_OUT, 1'b1);

    // Fill the FIFO during a slow frame, overflow it, then exercise the clear.
    expQ.delete();
    for (int w = 1; w <= 9; w++) pushFrame(8'(w), 32);
    applyStimulus(8'h01, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 2881; n++) begin
      @(negedge CLK);
      if (n >= 2) checkOutput($sformatf("ovf_tx[%0d]", n - 2), TX_OUT, expQ[n-2]);
      if (n == 9) begin
        checkOutput("ovf_count8", COUNT, 4'd8);
        checkOutput("ovf_full", FULL, 1'b1);
        checkOutput("ovf_not_yet", OVERFLOW, 1'b0);
      end
      if (n == 10) begin
        checkOutput("ovf_set", OVERFLOW, 1'b1);
        checkOutput("ovf_count_held", COUNT, 4'd8);
      end
      if (n == 11) checkOutput("ovf_set_wins", OVERFLOW, 1'b1);
      if (n == 12) checkOutput("ovf_cleared", OVERFLOW, 1'b0);
      if (n == 322) begin
        checkOutput("ovf_count7", COUNT, 4'd7);
        checkOutput("ovf_full_drop", FULL, 1'b0);
      end
      if (n <= 8)       applyStimulus(8'(n + 1), 1'b1, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (n == 9)  applyStimulus(8'hFF, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (n == 10) applyStimulus(8'hFF, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (n == 11) applyStimulus(8'hFF, 1'b0, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (n == 12) OVF_CLR = 1'b0;
    end
    @(negedge CLK);
    checkOutput("ovf_end_busy", Busy, 1'b0);
    checkOutput("ovf_end_count", COUNT, 4'd0);
    checkOutput("ovf_end_tx", TX_OUT, 1'b1);

    // Asynchronous reset in the middle of a data bit with two words queued.
    expQ.delete();
    pushFrame(8'hA5, 4);
    applyStimulus(8'hA5, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 11; n++) begin
      @(negedge CLK);
      if (n >= 2) checkOutput($sformatf("rstm_tx[%0d]", n - 2), TX_OUT, expQ[n-2]);
      if (n == 3) checkOutput("rstm_count2", COUNT, 4'd2);
      if (n == 1)      WR_Data = 8'h5A;
      else if (n == 2) WR_Data = 8'h33;
      else             WR_En = 1'b0;
    end
    RST = 1'b1;
    #1;
    checkOutput("rstm_tx_high", TX_OUT, 1'b1);
    checkOutput("rstm_busy", Busy, 1'b0);
    checkOutput("rstm_count", COUNT, 4'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      checkOutput($sformatf("rstm_quiet_busy[%0d]", n), Busy, 1'b0);
      checkOutput($sformatf("rstm_quiet_tx[%0d]", n), TX_OUT, 1'b1);
    end

    // Table of single frames; config inputs are scrambled once each frame starts.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].data, 1'b1, vecs[v].presc, vecs[v].parEn, vecs[v].parTyp, vecs[v].stop2, 1'b0);
      @(negedge CLK);
      checkOutput($sformatf("v%0d_count1", v), COUNT, 4'd1);
      checkOutput($sformatf("v%0d_pre_busy", v), Busy, 1'b0);
      checkOutput($sformatf("v%0d_pre_tx", v), TX_OUT, 1'b1);
      WR_En = 1'b0;
      @(negedge CLK);
      checkOutput($sformatf("v%0d_busy_start", v), Busy, 1'b1);
      applyStimulus(8'h00, 1'b0, 6'd7, ~vecs[v].parEn, ~vecs[v].parTyp, ~vecs[v].stop2, 1'b0);
      for (int k = 0; k < vecs[v].bits.len(); k++) begin
        for (int c = 0; c < vecs[v].period; c++) begin
          checkOutput($sformatf("v%0d_bit%0d_c%0d", v, k, c), TX_OUT, vecs[v].bits.getc(k) == 8'h31);
          checkOutput($sformatf("v%0d_busy_b%0d", v, k), Busy, 1'b1);
          @(negedge CLK);
        end
      end
      checkOutput($sformatf("v%0d_end_busy", v), Busy, 1'b0);
      checkOutput($sformatf("v%0d_end_tx", v), TX_OUT, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
